// File: rtl/event_arbiter.sv
// Event arbiter: captures per-channel event pulses into sticky pending bits and
// serialises them, one 1-based channel index per valid/ready handshake.
module event_arbiter #(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int RR = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M:0]   out_idx,
    output logic [N-1:0] pending,
    output logic [N-1:0] ovf,
    output logic         busy,
    output logic         state_dbg
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Handshake: out_idx transfers on a rising edge where out_valid & out_ready;
    // while out_valid=1 and out_ready=0, out_valid and out_idx stay unchanged.
    typedef enum logic {IDLE, OFFER} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_last;
    logic [IW-1:0]   win;
    logic            any;
    logic            load, drop;
    logic [N-1:0]    grant_clr;
    logic [N-1:0]    pending_d;
    logic [N-1:0]    ovf_set;
    logic            valid_d;
    logic [M:0]      idx_d;
    logic            busy_d;

    assign state_dbg = state_q;

    // Winner search over the registered pending vector.
    always_comb begin
        int start;
        int j;
        win   = '0;
        any   = 1'b0;
        start = 0;
        j     = 0;
        if (RR == 0) begin
            for (int i = 0; i < N; i++) begin
                if (pending[i]) begin
                    win = IW'(i);
                    any = 1'b1;
                end
            end
        end else begin
            // Descend from just below the last grant, so the last winner ranks lowest.
            start = (rr_last == '0) ? N - 1 : int'(rr_last) - 1;
            for (int k = 0; k < N; k++) begin
                j = start - k;
                if (j < 0) j = j + N;
                if (!any && pending[j]) begin
                    win = IW'(j);
                    any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        drop      = 1'b0;
        grant_clr = '0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    load    = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (out_ready) begin
                    if (any) begin
                        load = 1'b1;
                    end else begin
                        drop    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) grant_clr = {{(N-1){1'b0}}, 1'b1} << win;

        pending_d = (pending & ~grant_clr) | (en ? req : '0);
        ovf_set   = en ? (req & pending & ~grant_clr) : '0;

        valid_d = out_valid;
        idx_d   = out_idx;
        if (load) begin
            valid_d = 1'b1;
            idx_d   = (M+1)'(win) + (M+1)'(1);
        end else if (drop) begin
            valid_d = 1'b0;
            idx_d   = '0;
        end
        busy_d = (|pending_d) | valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending   <= '0;
            ovf       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            busy      <= 1'b0;
            rr_last   <= '0;
        end else if (clr) begin
            // rr_last survives clr so round-robin fairness carries across a flush.
            state_q   <= IDLE;
            pending   <= '0;
            ovf       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending   <= pending_d;
            ovf       <= ovf | ovf_set;
            out_valid <= valid_d;
            out_idx   <= idx_d;
            busy      <= busy_d;
            if (load) rr_last <= win;
        end
    end

endmodule
